// File: rtl/la_cap_pkg.sv
// la_cap_pkg: shared widths, beat counts and serializer states.
// Entry layout and beat count follow LA_CAPTURE_TIMESTAMP_EN.
package la_cap_pkg;

  localparam int LA_W = 128;
  localparam int BEAT_W = 32;

`ifdef LA_CAPTURE_TIMESTAMP_EN
  localparam int N_BEATS = 5;
  localparam int ENTRY_W = LA_W + BEAT_W;
`else
  localparam int N_BEATS = 4;
  localparam int ENTRY_W = LA_W;
`endif

  localparam int BEAT_CW = 3;
  localparam logic [BEAT_CW-1:0] BEAT_LAST =
    BEAT_CW'(N_BEATS - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_e;

endpackage

// File: rtl/la_sample_capture_if.sv
// la_sample_capture_if: push/pop bundle between the capture
// logic (master) and its sample FIFO (slave).
interface la_sample_capture_if #(
  parameter int W = 128,
  parameter int DEPTH = 4
);

  localparam int LW = $clog2(DEPTH + 1);

  logic         push;
  logic [W-1:0] wdata;
  logic         pop;
  logic [W-1:0] head;
  logic [W-1:0] head_nxt;
  logic         full;
  logic         empty;
  logic [LW-1:0] level;

  modport master (
    output push, wdata, pop,
    input  head, head_nxt, full, empty, level
  );

  modport slave (
    input  push, wdata, pop,
    output head, head_nxt, full, empty, level
  );

endinterface

// File: rtl/la_cap_fifo.sv
// la_cap_fifo: synchronous FIFO; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module la_cap_fifo #(
  parameter int W = 128,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  la_sample_capture_if.slave f
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign f.full = (cnt_q == LW'(DEPTH));
  assign f.empty = (cnt_q == '0);
  assign f.level = cnt_q;
  assign f.head = mem_q[rd_q];
  assign f.head_nxt = mem_q[rd_q + PW'(1)];

  assign do_pop = f.pop && !f.empty;
  assign do_push = f.push && (!f.full || do_pop);

  // pointer and occupancy update
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop) rd_d = rd_q + PW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + LW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - LW'(1);
  end

  // pointer/count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= f.wdata;
  end

endmodule

// File: rtl/la_sample_capture.sv
// la_sample_capture: change-triggered 128-bit capture, serialized
// as 32-bit beats. Define LA_CAPTURE_TIMESTAMP_EN for a 5th beat.
module la_sample_capture
  import la_cap_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [LA_W-1:0]            la_output,
  input  logic                       cap_en,
  input  logic                       ovf_clr,
  output logic [BEAT_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int LW = $clog2(DEPTH + 1);

  la_sample_capture_if #(
    .W(ENTRY_W),
    .DEPTH(DEPTH)
  ) fif ();

  la_cap_fifo #(
    .W(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk(sys_clk),
    .rst(sys_rst),
    .f(fif.slave)
  );

  logic [LA_W-1:0]    la_prev_q, la_prev_d;
  logic               ovf_q, ovf_d;
  ser_state_e         state_q, state_d;
  logic [BEAT_CW-1:0] beat_q, beat_d;
  logic [ENTRY_W-1:0] sample_q, sample_d;
  logic               cap_hit;
  logic               pop;
  logic               drop;

  assign la_prev_d = la_output;
  assign cap_hit = cap_en && (la_output != la_prev_q);
  assign drop = cap_hit && fif.full && !pop;
  assign fif.push = cap_hit;
  assign fif.pop = pop;
  assign fifo_level = LW'(fif.level);
  assign overflow = ovf_q;

`ifdef LA_CAPTURE_TIMESTAMP_EN
  logic [BEAT_W-1:0] ts_q, ts_d;
  assign ts_d = ts_q + BEAT_W'(1);
  assign fif.wdata = {ts_q, la_output};
`else
  assign fif.wdata = la_output;
`endif

  // sticky drop flag; a drop wins over a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  // serializer next-state, beat select and pop on last beat
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    sample_d = sample_q;
    pop = 1'b0;
    out_valid = 1'b0;
    out_last = 1'b0;
    out_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!fif.empty) begin
          state_d = S_SEND;
          sample_d = fif.head;
          beat_d = '0;
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last = (beat_q == BEAT_LAST);
        for (int i = 0; i < N_BEATS; i++) begin
          if (beat_q == BEAT_CW'(i))
            out_data = sample_q[i*BEAT_W +: BEAT_W];
        end
        if (out_ready) begin
          if (out_last) begin
            pop = 1'b1;
            beat_d = '0;
            if (fif.level > LW'(1))
              sample_d = fif.head_nxt;
            else
              state_d = S_IDLE;
          end else begin
            beat_d = beat_q + BEAT_CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      la_prev_q <= '0;
      ovf_q <= 1'b0;
      state_q <= S_IDLE;
      beat_q <= '0;
      sample_q <= '0;
`ifdef LA_CAPTURE_TIMESTAMP_EN
      ts_q <= '0;
`endif
    end else begin
      la_prev_q <= la_prev_d;
      ovf_q <= ovf_d;
      state_q <= state_d;
      beat_q <= beat_d;
      sample_q <= sample_d;
`ifdef LA_CAPTURE_TIMESTAMP_EN
      ts_q <= ts_d;
`endif
    end
  end

endmodule
